// File: rtl/pool_window_gen.sv
// Streaming 2x2 stride-2 window generator for max pooling.
// One row is held in a line buffer; each odd-row/odd-col pixel completes a window.
module pool_window_gen #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned FMAP_WIDTH  = 28,
    parameter int unsigned FMAP_HEIGHT = 28
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic signed [DATA_WIDTH-1:0] pix_in,
    input  logic                         pix_valid,
    output logic signed [DATA_WIDTH-1:0] win_out [4],
    output logic                         win_valid,
    output logic                         frame_done
);

    localparam int unsigned COL_W    = $clog2(FMAP_WIDTH);
    localparam int unsigned ROW_W    = $clog2(FMAP_HEIGHT);
    localparam int unsigned LAST_COL = 2 * (FMAP_WIDTH / 2) - 1;
    localparam int unsigned LAST_ROW = 2 * (FMAP_HEIGHT / 2) - 1;

    logic [COL_W-1:0]             col_q, col_d;
    logic [ROW_W-1:0]             row_q, row_d;
    logic signed [DATA_WIDTH-1:0] left_q;
    logic signed [DATA_WIDTH-1:0] lb [FMAP_WIDTH];

    logic accept;
    logic trig;
    logic last_win;

    assign accept   = pix_valid && !clr;
    // An odd col on an odd row never lands in a dropped column/row: with odd
    // dimensions the dropped last index is even, so no extra bound is needed.
    assign trig     = accept && row_q[0] && col_q[0];
    assign last_win = (row_q == ROW_W'(LAST_ROW)) && (col_q == COL_W'(LAST_COL));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == COL_W'(FMAP_WIDTH - 1)) begin
                col_d = '0;
                row_d = (row_q == ROW_W'(FMAP_HEIGHT - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            left_q     <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                win_out[i] <= '0;
            end
        end else if (clr) begin
            col_q      <= '0;
            row_q      <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            win_valid  <= trig;
            frame_done <= trig && last_win;
            if (accept && row_q[0] && !col_q[0]) begin
                left_q <= pix_in;
            end
            if (trig) begin
                win_out[0] <= lb[col_q - 1'b1];
                win_out[1] <= lb[col_q];
                win_out[2] <= left_q;
                win_out[3] <= pix_in;
            end
        end
    end

    // Line buffer is deliberately unreset; every entry is rewritten on an even row before use.
    always_ff @(posedge clk) begin
        if (accept && !row_q[0]) begin
            lb[col_q] <= pix_in;
        end
    end

endmodule

// File: tb/tb_pool_window_gen.sv
// Scoreboard bench for pool_window_gen: 4x4, 5x5 and 2x2 instances driven by directed steps.
module tb_pool_window_gen;

    typedef struct {
        logic [31:0] win;
        logic        fd;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;
    int   strobes4 = 0;
    int   fds4 = 0;

    logic              clr4 = 1'b0, v4 = 1'b0, v5 = 1'b0, v2 = 1'b0;
    logic              clr_off = 1'b0;
    logic signed [7:0] p4 = '0, p5 = '0, p2 = '0;
    logic signed [7:0] w4 [4];
    logic signed [7:0] w5 [4];
    logic signed [7:0] w2 [4];
    logic              wv4, wv5, wv2, fd4, fd5, fd2;

    exp_t q4[$];
    exp_t q5[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pool_window_gen #(.DATA_WIDTH(8), .FMAP_WIDTH(4), .FMAP_HEIGHT(4)) u4 (
        .clk(clk), .rst_n(rst_n), .clr(clr4), .pix_in(p4), .pix_valid(v4),
        .win_out(w4), .win_valid(wv4), .frame_done(fd4)
    );
    pool_window_gen #(.DATA_WIDTH(8), .FMAP_WIDTH(5), .FMAP_HEIGHT(5)) u5 (
        .clk(clk), .rst_n(rst_n), .clr(clr_off), .pix_in(p5), .pix_valid(v5),
        .win_out(w5), .win_valid(wv5), .frame_done(fd5)
    );
    pool_window_gen #(.DATA_WIDTH(8), .FMAP_WIDTH(2), .FMAP_HEIGHT(2)) u2 (
        .clk(clk), .rst_n(rst_n), .clr(clr_off), .pix_in(p2), .pix_valid(v2),
        .win_out(w2), .win_valid(wv2), .frame_done(fd2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input int which, input logic [31:0] win, input logic fd);
        exp_t e;
        e.win = win;
        e.fd  = fd;
        e.cyc = cyc;
        case (which)
            0:       q4.push_back(e);
            1:       q5.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic check(input int which, input string tag, input logic [31:0] win,
                         input logic fd, input logic wv);
        exp_t e;
        int   n;
        n = (which == 0) ? q4.size() : (which == 1) ? q5.size() : q2.size();
        tests++;
        assert (wv === 1'b1 && n > 0) else begin
            failed++;
            $error("FAIL %s strobe: win_valid=%0b frame_done=%0b queued=%0d, expected a queued window",
                   tag, wv, fd, n);
        end
        if (n > 0) begin
            case (which)
                0:       e = q4.pop_front();
                1:       e = q5.pop_front();
                default: e = q2.pop_front();
            endcase
            chk({tag, " window"}, win, e.win);
            chk({tag, " frame_done"}, {31'd0, fd}, {31'd0, e.fd});
            chk({tag, " latency cycle"}, cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (wv4 || fd4) begin
            strobes4 += wv4 ? 1 : 0;
            fds4     += fd4 ? 1 : 0;
            check(0, "w4x4", {w4[3], w4[2], w4[1], w4[0]}, fd4, wv4);
        end
        if (wv5 || fd5) check(1, "w5x5", {w5[3], w5[2], w5[1], w5[0]}, fd5, wv5);
        if (wv2 || fd2) check(2, "w2x2", {w2[3], w2[2], w2[1], w2[0]}, fd2, wv2);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int which, input logic signed [7:0] pix, input logic c);
        case (which)
            0:       begin p4 = pix; v4 = 1'b1; clr4 = c; end
            1:       begin p5 = pix; v5 = 1'b1; end
            default: begin p2 = pix; v2 = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        v4 = 1'b0; v5 = 1'b0; v2 = 1'b0; clr4 = 1'b0;
    endtask

    function automatic logic [7:0] pv(input int base, input int w, input int r, input int c);
        int v;
        v = base + r * w + c;
        return v[7:0];
    endfunction

    // Pixels base.. in raster order; expected windows come from raster addressing.
    task automatic run_frame(input int which, input int w, input int h, input int base,
                             input bit gaps, input int npix);
        int idx;
        idx = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (idx < npix) begin
                    if (gaps) idle($urandom_range(0, 2));
                    if (gaps && r == 1 && c == 1) idle(3);
                    send(which, pv(base, w, r, c), 1'b0);
                    if (r % 2 == 1 && c % 2 == 1 && r < 2 * (h / 2) && c < 2 * (w / 2)) begin
                        push(which, {pv(base, w, r, c), pv(base, w, r, c - 1),
                                     pv(base, w, r - 1, c), pv(base, w, r - 1, c - 1)},
                             (r == 2 * (h / 2) - 1) && (c == 2 * (w / 2) - 1));
                    end
                end
                idx++;
            end
        end
    endtask

    initial begin
        #12;
        chk("reset win_out", {w4[3], w4[2], w4[1], w4[0]}, 32'd0);
        chk("reset win_valid", {31'd0, wv4}, 32'd0);
        chk("reset frame_done", {31'd0, fd4}, 32'd0);
        chk("reset 5x5 win_out", {w5[3], w5[2], w5[1], w5[0]}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        run_frame(0, 4, 4, 0, 1'b0, 16);
        idle(3);
        run_frame(0, 4, 4, 0, 1'b1, 16);
        idle(3);

        run_frame(1, 5, 5, 0, 1'b0, 25);
        run_frame(1, 5, 5, 25, 1'b0, 25);
        idle(3);

        send(2, -8'sd128, 1'b0);
        send(2, 8'sd127, 1'b0);
        send(2, -8'sd1, 1'b0);
        send(2, 8'sd0, 1'b0);
        push(2, {8'h00, 8'hFF, 8'h7F, 8'h80}, 1'b1);
        idle(3);

        // Asynchronous reset mid-frame, applied away from any clock edge.
        run_frame(0, 4, 4, 0, 1'b0, 10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset win_out", {w4[3], w4[2], w4[1], w4[0]}, 32'd0);
        chk("async reset win_valid", {31'd0, wv4}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        run_frame(0, 4, 4, 0, 1'b0, 16);
        idle(3);

        // clr with a simultaneous pixel: that pixel must be discarded.
        run_frame(0, 4, 4, 0, 1'b0, 10);
        send(0, 8'sd99, 1'b1);
        run_frame(0, 4, 4, 0, 1'b0, 16);
        idle(3);

        strobes4 = 0;
        fds4     = 0;
        run_frame(0, 4, 4, 0, 1'b0, 16);
        run_frame(0, 4, 4, 16, 1'b0, 16);
        idle(3);
        chk("back-to-back window count", strobes4, 32'd8);
        chk("back-to-back frame_done count", fds4, 32'd2);

        chk("4x4 leftover expectations", q4.size(), 32'd0);
        chk("5x5 leftover expectations", q5.size(), 32'd0);
        chk("2x2 leftover expectations", q2.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
